// File: rtl/synth_pkg.sv
// synth_pkg: slot-field widths, slot tag type and tag-to-address mapping for osc_phase_acc
package synth_pkg;
    localparam int VOICES     = 8;
    localparam int V_OSC      = 4;
    localparam int V_WIDTH    = 3;
    localparam int O_WIDTH    = 2;
    localparam int OE_WIDTH   = 1;
    localparam int PITCH_LAT  = 3;
    localparam int ACC_WIDTH  = 32;
    localparam int E_WIDTH    = O_WIDTH + OE_WIDTH;
    localparam int SLOT_WIDTH = V_WIDTH + E_WIDTH;
    localparam int ADDR_WIDTH = V_WIDTH + O_WIDTH;
    localparam int FRAME_LEN  = 1 << SLOT_WIDTH;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [V_WIDTH-1:0]  vx;
        logic [O_WIDTH-1:0]  ox;
        logic [OE_WIDTH-1:0] oe;
    } slot_t;

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input slot_t s);
        return {s.vx, s.ox};
    endfunction
endpackage

// File: rtl/phase_ram.sv
// phase_ram: simple dual-port phase memory, registered read, no reset
module phase_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/osc_phase_acc.sv
// osc_phase_acc: time-multiplexed per-oscillator phase accumulator with note-on phase clear.
// Define OSC_HARD_SYNC_EN to reset osc 1 of a voice after each osc 0 wrap.
module osc_phase_acc
    import synth_pkg::*;
(
    input  logic                  sCLK_XVXOSC,
    input  logic                  reset_reg,
    input  logic [SLOT_WIDTH-1:0] xxxx,
    input  logic [23:0]           osc_pitch_val,
    input  logic                  note_on,
    input  logic [V_WIDTH-1:0]    cur_key_adr,
    output logic [ACC_WIDTH-1:0]  phase_out,
    output logic [ADDR_WIDTH-1:0] phase_tag,
    output logic                  phase_valid,
    output logic                  phase_wrap
);
    if (FRAME_LEN < 4) begin : g_frame_chk
        $error("osc_phase_acc: frame length must be at least 4");
    end

    slot_t                       dly [PITCH_LAT];
    logic [PITCH_LAT-1:0]        dly_v;
    slot_t                       t;
    logic                        hit;
    logic                        v0, v1;
    logic [ADDR_WIDTH-1:0]       a0, a1;
    logic [23:0]                 inc0, inc1;
    logic [ACC_WIDTH-1:0]        rd;
    logic [VOICES-1:0][V_OSC-1:0] pend;
    logic [V_WIDTH-1:0]          vx;
    logic [O_WIDTH-1:0]          ox;
    logic                        zero;
    logic [ACC_WIDTH:0]          sum;
`ifdef OSC_HARD_SYNC_EN
    logic [VOICES-1:0]           sync;
`endif

    always_comb begin
        t = dly[PITCH_LAT-1];
        hit = dly_v[PITCH_LAT-1] && t.oe == '0 && 32'(t.vx) < VOICES && 32'(t.ox) < V_OSC;
        vx = a1[ADDR_WIDTH-1:O_WIDTH];
        ox = a1[O_WIDTH-1:0];
        // a note_on landing on this very update zeroes it as well as the next visit
        zero = pend[vx][ox] || (note_on && cur_key_adr == vx)
`ifdef OSC_HARD_SYNC_EN
            || (ox == O_WIDTH'(1) && sync[vx])
`endif
            ;
        sum = (zero ? '0 : {1'b0, rd}) + (ACC_WIDTH+1)'(inc1);
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        dly[0] <= xxxx;
        for (int i = 1; i < PITCH_LAT; i++) dly[i] <= dly[i-1];
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset_reg) begin
            dly_v       <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            phase_out   <= '0;
            phase_tag   <= '0;
            phase_valid <= 1'b0;
            phase_wrap  <= 1'b0;
            pend        <= '1;
        end else begin
            dly_v       <= PITCH_LAT'({dly_v, 1'b1});
            v0          <= hit;
            a0          <= slot_addr(t);
            inc0        <= osc_pitch_val;
            v1          <= v0;
            a1          <= a0;
            inc1        <= inc0;
            phase_valid <= v1;
            if (v1) begin
                phase_out  <= sum[ACC_WIDTH-1:0];
                phase_tag  <= a1;
                phase_wrap <= sum[ACC_WIDTH];
                pend[vx][ox] <= 1'b0;
            end
            if (note_on) pend[cur_key_adr] <= '1;
        end
    end

`ifdef OSC_HARD_SYNC_EN
    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset_reg) begin
            sync <= '0;
        end else begin
            if (v1 && ox == O_WIDTH'(1)) sync[vx] <= 1'b0;
            if (note_on) sync[cur_key_adr] <= 1'b0;
            if (v1 && ox == '0 && sum[ACC_WIDTH]) sync[vx] <= 1'b1;
        end
    end
`endif

    phase_ram #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH), .DW(ACC_WIDTH)) u_ram (
        .clk (sCLK_XVXOSC),
        .we  (v1 && !reset_reg),
        .wa  (a1),
        .wd  (sum[ACC_WIDTH-1:0]),
        .ra  (a0),
        .rd  (rd)
    );
endmodule
